fp_align_acc: RTL and testbench



---
 rtl/fp_align_acc.sv | 145 ++++++++++++++
 tb/tb_fp_align_acc.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/fp_align_acc.sv
// Block-floating-point align/accumulate/normalise stage fed by the max-exponent stage.
// Optional macro FP_ALIGN_RND_EN: round half-up on every alignment shift.
module fp_align_acc #(
  parameter int EXP_WIDTH = 6,
  parameter int MAN_WIDTH = 8,
  parameter int ACC_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_last,
  input  logic [3:0][EXP_WIDTH-1:0] v_exp,
  input  logic [3:0][MAN_WIDTH-1:0] v_man,
  input  logic [EXP_WIDTH-1:0]      max_exp,
  output logic [EXP_WIDTH-1:0]      acc_exp_o,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [EXP_WIDTH-1:0]      out_exp,
  output logic [ACC_WIDTH-1:0]      out_man
);

  localparam int SW = ACC_WIDTH + 3;
  localparam int NW = $clog2(ACC_WIDTH);

  typedef enum logic [1:0] {IDLE, ACC, NORM, DONE} state_t;

  state_t state, state_nx;

  logic signed [ACC_WIDTH-1:0] acc_man;
  logic signed [SW-1:0]        sum;
  logic [ACC_WIDTH-1:0]        sat;
  logic [NW-1:0]               n;
  logic                        run;
  logic [EXP_WIDTH-1:0]        s;
  logic                        acc_en;
  logic                        drain;

  // An exponent above max_exp is a protocol violation; treat it as aligned.
  function automatic logic [EXP_WIDTH-1:0] shamt(
    input logic [EXP_WIDTH-1:0] m,
    input logic [EXP_WIDTH-1:0] e
  );
    return (e > m) ? '0 : m - e;
  endfunction

  function automatic logic signed [SW-1:0] align(
    input logic signed [ACC_WIDTH-1:0] v,
    input logic [EXP_WIDTH-1:0]        sh
  );
    logic signed [ACC_WIDTH-1:0] q;
    logic                        r;
    q = v >>> sh;
    r = 1'b0;
`ifdef FP_ALIGN_RND_EN
    if (sh != '0) begin
      if (int'(sh) > ACC_WIDTH) r = v[ACC_WIDTH-1];
      else r = v[int'(sh) - 1];
    end
`endif
    return {{(SW-ACC_WIDTH){q[ACC_WIDTH-1]}}, q}
         + {{(SW-1){1'b0}}, r};
  endfunction

  assign in_ready = (state == IDLE) || (state == ACC);
  assign acc_en   = in_valid && in_ready;
  assign drain    = (state == DONE) && out_ready;

  always_comb begin
    sum = '0;
    for (int i = 0; i < 4; i++) begin
      sum = sum + align(
        ACC_WIDTH'($signed(v_man[i])),
        shamt(max_exp, v_exp[i]));
    end
    if (state != IDLE) begin
      sum = sum + align(acc_man, shamt(max_exp, acc_exp_o));
    end
  end

  always_comb begin
    if (sum[SW-1:ACC_WIDTH-1] == '0 || sum[SW-1:ACC_WIDTH-1] == '1) begin
      sat = sum[ACC_WIDTH-1:0];
    end else if (sum[SW-1]) begin
      sat = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    end else begin
      sat = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end
  end

  // Redundant sign bits below the sign bit, clamped so out_exp stays >= 0.
  always_comb begin
    n   = '0;
    run = 1'b1;
    for (int i = ACC_WIDTH - 2; i >= 0; i--) begin
      if (acc_man[i] != acc_man[ACC_WIDTH-1]) run = 1'b0;
      if (run) n = n + 1'b1;
    end
    s = (EXP_WIDTH'(n) < acc_exp_o) ? EXP_WIDTH'(n) : acc_exp_o;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (acc_en) state_nx = in_last ? NORM : ACC;
      ACC:  if (acc_en && in_last) state_nx = NORM;
      NORM: state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc_man   <= '0;
      acc_exp_o <= '0;
      out_valid <= 1'b0;
      out_exp   <= '0;
      out_man   <= '0;
    end else begin
      state <= state_nx;
      if (acc_en) begin
        acc_man   <= sat;
        acc_exp_o <= max_exp;
      end else if (drain) begin
        acc_man   <= '0;
        acc_exp_o <= '0;
      end
      if (state == NORM) begin
        out_valid <= 1'b1;
        if (acc_man == '0) begin
          out_man <= '0;
          out_exp <= '0;
        end else begin
          out_man <= acc_man << s;
          out_exp <= acc_exp_o - s;
        end
      end else if (drain) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fp_align_acc.sv
// Directed vector bench for fp_align_acc.
// Table vectors plus backpressure, saturation and mid-accumulation reset.
module tb_fp_align_acc;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic            in_last;
  logic [3:0][5:0] v_exp;
  logic [3:0][7:0] v_man;
  logic [5:0]      max_exp;
  logic [5:0]      acc_exp_o;
  logic            out_valid;
  logic            out_ready;
  logic [5:0]      out_exp;
  logic [15:0]     out_man;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fp_align_acc dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .v_exp     (v_exp),
    .v_man     (v_man),
    .max_exp   (max_exp),
    .acc_exp_o (acc_exp_o),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_exp   (out_exp),
    .out_man   (out_man)
  );

  typedef struct packed {
    logic [3:0][5:0] e;
    logic [3:0][7:0] m;
    logic [5:0]      mx;
  } beat_t;

  typedef struct {
    string name;
    int    nb;
    beat_t b0;
    beat_t b1;
    logic [15:0] om;
    logic [5:0]  oe;
  } vec_t;

  function automatic logic [3:0][5:0] mk_e(int a0, int a1, int a2, int a3);
    return {6'(a3), 6'(a2), 6'(a1), 6'(a0)};
  endfunction

  function automatic logic [3:0][7:0] mk_m(int a0, int a1, int a2, int a3);
    return {8'(a3), 8'(a2), 8'(a1), 8'(a0)};
  endfunction

  function automatic beat_t mk_b(logic [3:0][5:0] e, logic [3:0][7:0] m, int mx);
    beat_t b;
    b.e  = e;
    b.m  = m;
    b.mx = 6'(mx);
    return b;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send(beat_t b, logic last);
    chk("in_ready_beat", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_last  = last;
    v_exp    = b.e;
    v_man    = b.m;
    max_exp  = b.mx;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Called right after the last beat's edge: checks latency, result, drain.
  task automatic finish_result(string name, logic [15:0] om, logic [5:0] oe);
    chk({name, "_valid_t1"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk({name, "_valid_t2"}, 32'(out_valid), 32'd1);
    chk({name, "_man"}, 32'(out_man), 32'(om));
    chk({name, "_exp"}, 32'(out_exp), 32'(oe));
    chk({name, "_in_ready_done"}, 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({name, "_valid_drain"}, 32'(out_valid), 32'd0);
    chk({name, "_accexp_drain"}, 32'(acc_exp_o), 32'd0);
    chk({name, "_in_ready_idle"}, 32'(in_ready), 32'd1);
  endtask

  vec_t vt[6];
  beat_t b1, b2, bs, bx;
  logic [15:0] hold_man;
  logic [5:0]  hold_exp;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    v_exp = '0; v_man = '0; max_exp = '0; out_ready = 1'b0;

    vt[0] = '{"single", 1, mk_b(mk_e(20,20,20,20), mk_m(1,2,3,4), 20),
              '0, 16'd20480, 6'd9};
    vt[1] = '{"align", 1, mk_b(mk_e(12,10,10,10), mk_m(4,4,4,4), 12),
              '0, 16'd28672, 6'd0};
    vt[2] = '{"two_beat", 2, mk_b(mk_e(8,8,8,8), mk_m(16,0,0,0), 8),
              mk_b(mk_e(10,10,10,10), mk_m(1,0,0,0), 10), 16'd5120, 6'd0};
    vt[3] = '{"negative", 1, mk_b(mk_e(20,20,20,20), mk_m(-1,-2,-3,-4), 20),
              '0, 16'hB000, 6'd9};
    vt[4] = '{"sign_fill", 1, mk_b(mk_e(40,0,40,40), mk_m(64,-128,0,0), 40),
              '0, 16'd32256, 6'd31};
    vt[5] = '{"zero_sum", 1, mk_b(mk_e(20,20,20,20), mk_m(1,-1,0,0), 20),
              '0, 16'd0, 6'd0};

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_acc_exp", 32'(acc_exp_o), 32'd0);
    chk("rst_out_man", 32'(out_man), 32'd0);
    chk("rst_out_exp", 32'(out_exp), 32'd0);

    for (int i = 0; i < 6; i++) begin
      if (vt[i].nb == 2) begin
        send(vt[i].b0, 1'b0);
        chk({vt[i].name, "_accexp_b1"}, 32'(acc_exp_o), 32'(vt[i].b0.mx));
        send(vt[i].b1, 1'b1);
      end else begin
        send(vt[i].b0, 1'b1);
      end
      finish_result(vt[i].name, vt[i].om, vt[i].oe);
    end

    // Exponent above max_exp: aligned with no shift.
    bx = mk_b(mk_e(25,20,20,20), mk_m(8,0,0,0), 20);
    send(bx, 1'b1);
    finish_result("exp_violation", 16'd16384, 6'd9);

    // Saturation over 65 beats of 4*127 at exponent 30.
    bs = mk_b(mk_e(30,30,30,30), mk_m(127,127,127,127), 30);
    for (int k = 0; k < 65; k++) send(bs, k == 64);
    finish_result("saturate", 16'd32767, 6'd30);

    // Backpressure: result held, extra beats ignored.
    b1 = mk_b(mk_e(20,20,20,20), mk_m(1,2,3,4), 20);
    send(b1, 1'b1);
    @(posedge clk); #1;
    chk("bp_valid", 32'(out_valid), 32'd1);
    hold_man = 16'd20480;
    hold_exp = 6'd9;
    bx = mk_b(mk_e(5,5,5,5), mk_m(100,100,100,100), 5);
    in_valid = 1'b1; in_last = 1'b1;
    v_exp = bx.e; v_man = bx.m; max_exp = bx.mx;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_man", 32'(out_man), 32'(hold_man));
      chk("bp_hold_exp", 32'(out_exp), 32'(hold_exp));
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_release_accexp", 32'(acc_exp_o), 32'd0);
    chk("bp_release_idle", 32'(in_ready), 32'd1);
    b2 = mk_b(mk_e(12,10,10,10), mk_m(4,4,4,4), 12);
    send(b2, 1'b1);
    finish_result("after_bp", 16'd28672, 6'd0);

    // Reset in the middle of an accumulation discards it.
    bx = mk_b(mk_e(15,15,15,15), mk_m(50,50,50,50), 15);
    for (int k = 0; k < 3; k++) send(bx, 1'b0);
    chk("mid_accexp", 32'(acc_exp_o), 32'd15);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("mid_rst_idle", 32'(in_ready), 32'd1);
    chk("mid_rst_accexp", 32'(acc_exp_o), 32'd0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    send(b1, 1'b1);
    finish_result("after_rst", 16'd20480, 6'd9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
